// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider producing one quotient
// bit per clock behind a start/busy/done handshake. Divide-by-zero is
// reported on the cycle after acceptance without iterating.
module seq_divider #(
    parameter int DIVIDEND_WIDTH = 16,
    parameter int DIVISOR_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      busy,
    output logic                      done,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero
);

    localparam int CW = $clog2(DIVIDEND_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q,     state_d;
    logic [CW-1:0]             count_q,     count_d;
    // work_q starts as the dividend and fills with quotient bits from the
    // right as the dividend bits are shifted out on the left.
    logic [DIVIDEND_WIDTH-1:0] work_q,      work_d;
    logic [DIVISOR_WIDTH-1:0]  divisor_q,   divisor_d;
    // The partial remainder between steps is always < divisor, so DIVISOR_WIDTH
    // bits hold it; the shifted value used for the compare is one bit wider.
    logic [DIVISOR_WIDTH-1:0]  partial_q,   partial_d;
    logic [DIVIDEND_WIDTH-1:0] quotient_q,  quotient_d;
    logic [DIVISOR_WIDTH-1:0]  remainder_q, remainder_d;
    logic                      dbz_q,       dbz_d;

    logic [DIVISOR_WIDTH:0]    shifted;
    logic                      q_bit;
    logic [DIVISOR_WIDTH-1:0]  partial_next;
    logic [DIVIDEND_WIDTH-1:0] work_next;

    // Next-state, datapath step and result capture for the three-state FSM.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        work_d       = work_q;
        divisor_d    = divisor_q;
        partial_d    = partial_q;
        quotient_d   = quotient_q;
        remainder_d  = remainder_q;
        dbz_d        = dbz_q;

        shifted      = {partial_q, work_q[DIVIDEND_WIDTH-1]};
        q_bit        = (shifted >= {1'b0, divisor_q});
        partial_next = q_bit ? (shifted[DIVISOR_WIDTH-1:0] - divisor_q)
                             : shifted[DIVISOR_WIDTH-1:0];
        work_next    = {work_q[DIVIDEND_WIDTH-2:0], q_bit};

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        state_d   = RUN;
                        work_d    = dividend;
                        divisor_d = divisor;
                        partial_d = '0;
                        count_d   = CW'(DIVIDEND_WIDTH);
                        dbz_d     = 1'b0;
                    end else begin
                        state_d     = DONE;
                        dbz_d       = 1'b1;
                        quotient_d  = '1;
                        remainder_d = '0;
                    end
                end
            end
            RUN: begin
                work_d    = work_next;
                partial_d = partial_next;
                count_d   = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d     = DONE;
                    quotient_d  = work_next;
                    remainder_d = partial_next;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            work_q      <= '0;
            divisor_q   <= '0;
            partial_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            work_q      <= work_d;
            divisor_q   <= divisor_d;
            partial_q   <= partial_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed stimulus for seq_divider with a
// queue-based scoreboard checked by an independent monitor.
module tb_seq_divider;

    localparam int W  = 16;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  dividend;
    logic [DW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [W-1:0]  quotient;
    logic [DW-1:0] remainder;
    logic          div_by_zero;

    typedef struct {
        logic [W-1:0]  q;
        logic [DW-1:0] r;
        logic          dbz;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            n_compared   = 0;
    int            n_mismatched = 0;
    int            cyc          = 0;
    logic          prev_done    = 1'b0;
    logic [W-1:0]  last_q       = '0;
    logic [DW-1:0] last_r       = '0;

    seq_divider #(.DIVIDEND_WIDTH(W), .DIVISOR_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to time when done is due.
    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point: counts every check, reports any difference.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Waits (bounded) for the divider to be idle, then issues one operation
    // and records the arithmetic answer the divider must produce.
    task automatic applyStimulus(input logic [W-1:0] dvd, input logic [DW-1:0] dvs);
        exp_t e;
        int   guard;
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy) checkOutput("idle_timeout", 32'(busy), 32'd0);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        if (dvs == 0) begin
            e.q   = {W{1'b1}};
            e.r   = '0;
            e.dbz = 1'b1;
            e.cyc = cyc + 1;
        end else begin
            e.q   = W'(int'(dvd) / int'(dvs));
            e.r   = DW'(int'(dvd) % int'(dvs));
            e.dbz = 1'b0;
            e.cyc = cyc + W + 1;
        end
        sb.push_back(e);
        last_q = e.q;
        last_r = e.r;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation,
    // arrive on time, and be followed by an idle cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_done <= 1'b0;
        end else begin
            if (prev_done) checkOutput("idle_after_done", {30'd0, busy, done}, 32'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("quotient",    32'(quotient),    32'(e.q));
                    checkOutput("remainder",   32'(remainder),   32'(e.r));
                    checkOutput("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                    checkOutput("done_cycle",  32'(cyc),         32'(e.cyc));
                    checkOutput("busy_at_done", 32'(busy),       32'd1);
                end
            end
            prev_done <= done;
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int guard;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy",      32'(busy),        32'd0);
        checkOutput("reset_done",      32'(done),        32'd0);
        checkOutput("reset_quotient",  32'(quotient),    32'd0);
        checkOutput("reset_remainder", 32'(remainder),   32'd0);
        checkOutput("reset_dbz",       32'(div_by_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(16'd100, 8'd7);
        applyStimulus(16'hFFFF, 8'd1);
        applyStimulus(16'hFFFF, 8'hFF);
        applyStimulus(16'd1234, 8'd0);

        applyStimulus(16'd5, 8'd200);
        start    = 1'b1;
        dividend = 16'd999;
        divisor  = 8'd3;
        repeat (10) @(negedge clk);
        start = 1'b0;

        applyStimulus(16'd100, 8'd7);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        checkOutput("midrun_reset_busy",      32'(busy),      32'd0);
        checkOutput("midrun_reset_done",      32'(done),      32'd0);
        checkOutput("midrun_reset_quotient",  32'(quotient),  32'd0);
        checkOutput("midrun_reset_remainder", 32'(remainder), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(16'd9, 8'd3);

        applyStimulus(16'd100, 8'd7);
        applyStimulus(16'd200, 8'd9);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0]  dvd;
            logic [DW-1:0] dvs;
            dvd = W'($urandom_range(0, 65535));
            case ($urandom_range(0, 9))
                0:       dvs = '0;
                1:       dvs = 8'd1;
                2:       dvs = 8'hFF;
                3: begin
                    dvs = DW'($urandom_range(2, 255));
                    dvd = W'($urandom_range(0, int'(dvs) - 1));
                end
                default: dvs = DW'($urandom_range(1, 255));
            endcase
            applyStimulus(dvd, dvs);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
        end

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("drain_outstanding", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("hold_quotient",  32'(quotient),  32'(last_q));
        checkOutput("hold_remainder", 32'(remainder), 32'(last_r));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
